// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use, branch-operand and Hi/Lo stalls, EX forwarding selects and a stall counter
module hazard_fwd_ctrl #(
  parameter int RA_W = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic id_use_rs,
  input  logic id_use_rt,
  input  logic id_is_branch,
  input  logic id_is_mul,
  input  logic id_rd_hilo,
  input  logic branch_taken,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic [RA_W-1:0] ex_dest,
  input  logic ex_regwrite,
  input  logic ex_memread,
  input  logic [RA_W-1:0] mem_dest,
  input  logic mem_regwrite,
  input  logic mem_memread,
  input  logic [RA_W-1:0] wb_dest,
  input  logic wb_regwrite,
  input  logic perf_clr,
  output logic pc_write,
  output logic ifid_write,
  output logic ifid_flush,
  output logic idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic hilo_busy,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int BW = $clog2(MUL_LAT + 1);
  logic [BW-1:0] busyCnt;
  logic rsEx, rtEx, rsMemLd, rtMemLd, rsMem, rtMem, rsWb, rtWb;
  logic lu, br, hl, stall;
  function automatic logic match(input logic [RA_W-1:0] x, input logic [RA_W-1:0] d, input logic w);
    return w && (d != '0) && (x == d);
  endfunction
  always_comb begin
    rsEx = id_use_rs && match(id_rs, ex_dest, ex_regwrite);
    rtEx = id_use_rt && match(id_rt, ex_dest, ex_regwrite);
    rsMemLd = id_use_rs && match(id_rs, mem_dest, mem_regwrite && mem_memread);
    rtMemLd = id_use_rt && match(id_rt, mem_dest, mem_regwrite && mem_memread);
    lu = ex_memread && (rsEx || rtEx);
    br = id_is_branch && (rsEx || rtEx || rsMemLd || rtMemLd);
    hl = (id_rd_hilo || id_is_mul) && hilo_busy;
    stall = lu || br || hl;
    rsMem = match(ex_rs, mem_dest, mem_regwrite) && !mem_memread;
    rtMem = match(ex_rt, mem_dest, mem_regwrite) && !mem_memread;
    rsWb = match(ex_rs, wb_dest, wb_regwrite);
    rtWb = match(ex_rt, wb_dest, wb_regwrite);
  end
  assign hilo_busy = busyCnt != '0;
  assign pc_write = rst_n && !stall;
  assign ifid_write = rst_n && !stall;
  assign idex_bubble = !rst_n || stall;
  // a stalled branch compared stale operands, so its flush waits for the release cycle
  assign ifid_flush = rst_n && branch_taken && !stall;
  assign fwd_a = !rst_n ? 2'b00 : rsMem ? 2'b01 : rsWb ? 2'b10 : 2'b00;
  assign fwd_b = !rst_n ? 2'b00 : rtMem ? 2'b01 : rtWb ? 2'b10 : 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busyCnt <= '0;
      stall_cycles <= '0;
    end else begin
      busyCnt <= (id_is_mul && !stall) ? BW'(MUL_LAT) : hilo_busy ? busyCnt - BW'(1) : busyCnt;
      stall_cycles <= perf_clr ? '0 : (stall && stall_cycles != '1) ? stall_cycles + CNT_W'(1) : stall_cycles;
    end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: table-driven combinational checks plus multi-cycle stall/multiply/reset sequences
module tb_hazard_fwd_ctrl;
  localparam int RA_W = 5;
  localparam int MUL_LAT = 4;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [RA_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic id_use_rs, id_use_rt, id_is_branch, id_is_mul, id_rd_hilo, branch_taken;
  logic ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, perf_clr;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, hilo_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  hazard_fwd_ctrl #(.RA_W(RA_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_is_mul(id_is_mul), .id_rd_hilo(id_rd_hilo), .branch_taken(branch_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_dest(mem_dest), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_dest(wb_dest),
    .wb_regwrite(wb_regwrite), .perf_clr(perf_clr), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .hilo_busy(hilo_busy),
    .stall_cycles(stall_cycles));
  typedef struct {
    logic [RA_W-1:0] idRs, idRt;
    logic useRs, useRt, isBr, taken;
    logic [RA_W-1:0] exRs, exRt, exDest;
    logic exRw, exMr;
    logic [RA_W-1:0] memDest;
    logic memRw, memMr;
    logic [RA_W-1:0] wbDest;
    logic wbRw;
    logic eStall, eFlush;
    logic [1:0] eFa, eFb;
  } vec_t;
  vec_t vecs[16];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic clearIn();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_dest = '0; mem_dest = '0; wb_dest = '0;
    id_use_rs = 0; id_use_rt = 0; id_is_branch = 0; id_is_mul = 0; id_rd_hilo = 0; branch_taken = 0;
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_memread = 0; wb_regwrite = 0;
  endtask
  task automatic applyVec(input vec_t v);
    id_rs = v.idRs; id_rt = v.idRt; id_use_rs = v.useRs; id_use_rt = v.useRt;
    id_is_branch = v.isBr; branch_taken = v.taken; ex_rs = v.exRs; ex_rt = v.exRt;
    ex_dest = v.exDest; ex_regwrite = v.exRw; ex_memread = v.exMr; mem_dest = v.memDest;
    mem_regwrite = v.memRw; mem_memread = v.memMr; wb_dest = v.wbDest; wb_regwrite = v.wbRw;
    id_is_mul = 0; id_rd_hilo = 0;
  endtask
  function automatic vec_t mk(input int idRs, idRt, useRs, useRt, isBr, taken, exRs, exRt, exDest, exRw, exMr,
                              memDest, memRw, memMr, wbDest, wbRw, eStall, eFlush, eFa, eFb);
    vec_t v;
    v.idRs = RA_W'(idRs); v.idRt = RA_W'(idRt); v.useRs = 1'(useRs); v.useRt = 1'(useRt);
    v.isBr = 1'(isBr); v.taken = 1'(taken); v.exRs = RA_W'(exRs); v.exRt = RA_W'(exRt);
    v.exDest = RA_W'(exDest); v.exRw = 1'(exRw); v.exMr = 1'(exMr); v.memDest = RA_W'(memDest);
    v.memRw = 1'(memRw); v.memMr = 1'(memMr); v.wbDest = RA_W'(wbDest); v.wbRw = 1'(wbRw);
    v.eStall = 1'(eStall); v.eFlush = 1'(eFlush); v.eFa = 2'(eFa); v.eFb = 2'(eFb);
    return v;
  endfunction
  initial begin
    //             idRs idRt uRs uRt br tk exRs exRt exD eRw eMr memD mRw mMr wbD wRw stall flush fa fb
    vecs[0]  = mk(5,  0,  1, 0, 0, 0, 0,  0,  5,  1, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0,  0,  1, 0, 0, 0, 0,  0,  0,  1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0,  9,  0, 1, 0, 0, 0,  0,  9,  1, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0,  9,  0, 0, 0, 0, 0,  0,  9,  1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(5,  0,  1, 0, 0, 0, 0,  0,  5,  1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(5,  0,  1, 0, 0, 0, 0,  0,  5,  0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0,  0,  0, 0, 0, 0, 7,  3,  0,  0, 0, 7,  1, 0, 7, 1, 0, 0, 1, 0);
    vecs[7]  = mk(0,  0,  0, 0, 0, 0, 7,  3,  0,  0, 0, 7,  1, 1, 7, 1, 0, 0, 2, 0);
    vecs[8]  = mk(0,  0,  0, 0, 0, 0, 4,  12, 0,  0, 0, 12, 1, 0, 4, 1, 0, 0, 2, 1);
    vecs[9]  = mk(0,  0,  0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk(4,  0,  1, 0, 1, 1, 0,  0,  4,  1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    vecs[11] = mk(0,  6,  0, 1, 1, 1, 0,  0,  0,  0, 0, 6,  1, 1, 0, 0, 1, 0, 0, 0);
    vecs[12] = mk(0,  6,  0, 1, 1, 1, 0,  0,  0,  0, 0, 6,  1, 0, 0, 0, 0, 1, 0, 0);
    vecs[13] = mk(3,  8,  1, 1, 1, 1, 0,  0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0);
    vecs[14] = mk(4,  0,  1, 0, 1, 0, 0,  0,  0,  0, 0, 0,  0, 0, 4, 1, 0, 0, 0, 0);
    vecs[15] = mk(0,  6,  0, 1, 1, 0, 0,  0,  0,  0, 0, 6,  0, 1, 0, 0, 0, 0, 0, 0);
    clearIn();
    perf_clr = 1;
    id_rs = 5; id_use_rs = 1; ex_dest = 5; ex_regwrite = 1; ex_memread = 1;
    ex_rs = 7; mem_dest = 7; mem_regwrite = 1; branch_taken = 1;
    #2;
    chk("reset pc_write", pc_write, 0);
    chk("reset ifid_write", ifid_write, 0);
    chk("reset idex_bubble", idex_bubble, 1);
    chk("reset ifid_flush", ifid_flush, 0);
    chk("reset fwd_a", fwd_a, 0);
    chk("reset hilo_busy", hilo_busy, 0);
    chk("reset stall_cycles", stall_cycles, 0);
    @(negedge clk);
    clearIn();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyVec(vecs[i]);
      #1;
      chk($sformatf("vec%0d idex_bubble", i), idex_bubble, vecs[i].eStall);
      chk($sformatf("vec%0d pc_write", i), pc_write, !vecs[i].eStall);
      chk($sformatf("vec%0d ifid_write", i), ifid_write, !vecs[i].eStall);
      chk($sformatf("vec%0d ifid_flush", i), ifid_flush, vecs[i].eFlush);
      chk($sformatf("vec%0d fwd_a", i), fwd_a, vecs[i].eFa);
      chk($sformatf("vec%0d fwd_b", i), fwd_b, vecs[i].eFb);
    end
    // load-use stall counts exactly one cycle
    @(negedge clk);
    clearIn();
    @(negedge clk);
    perf_clr = 0;
    id_rs = 5; id_use_rs = 1; ex_dest = 5; ex_regwrite = 1; ex_memread = 1;
    #1;
    chk("lu stall_cycles before", stall_cycles, 0);
    chk("lu pc_write", pc_write, 0);
    @(negedge clk);
    clearIn();
    #1;
    chk("lu stall_cycles after", stall_cycles, 1);
    chk("lu released pc_write", pc_write, 1);
    // branch stall suppresses flush, flush fires on release
    @(negedge clk);
    id_is_branch = 1; id_rs = 4; id_use_rs = 1; ex_dest = 4; ex_regwrite = 1; branch_taken = 1;
    #1;
    chk("br stalled flush", ifid_flush, 0);
    chk("br stalled pc_write", pc_write, 0);
    @(negedge clk);
    ex_regwrite = 0;
    #1;
    chk("br release flush", ifid_flush, 1);
    chk("br release pc_write", pc_write, 1);
    // multiply interlock
    @(negedge clk);
    clearIn();
    perf_clr = 1;
    @(negedge clk);
    perf_clr = 0;
    id_is_mul = 1;
    #1;
    chk("mul accept hilo_busy", hilo_busy, 0);
    chk("mul accept pc_write", pc_write, 1);
    @(negedge clk);
    id_is_mul = 0; id_rd_hilo = 1;
    for (int i = 1; i <= MUL_LAT; i++) begin
      #1;
      chk($sformatf("mul t+%0d hilo_busy", i), hilo_busy, 1);
      chk($sformatf("mul t+%0d idex_bubble", i), idex_bubble, 1);
      @(negedge clk);
    end
    #1;
    chk("mul release hilo_busy", hilo_busy, 0);
    chk("mul release pc_write", pc_write, 1);
    chk("mul stall_cycles", stall_cycles, MUL_LAT);
    // saturation and clear
    @(negedge clk);
    clearIn();
    id_rs = 5; id_use_rs = 1; ex_dest = 5; ex_regwrite = 1; ex_memread = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat stall_cycles", stall_cycles, 15);
    repeat (3) @(negedge clk);
    #1;
    chk("sat hold stall_cycles", stall_cycles, 15);
    @(negedge clk);
    perf_clr = 1;
    @(negedge clk);
    perf_clr = 0;
    #1;
    chk("clr stall_cycles", stall_cycles, 0);
    @(negedge clk);
    #1;
    chk("clr then count", stall_cycles, 1);
    // reset in the middle of a multiply
    @(negedge clk);
    clearIn();
    id_is_mul = 1;
    @(negedge clk);
    id_is_mul = 0;
    @(negedge clk);
    #1;
    chk("rst pre hilo_busy", hilo_busy, 1);
    ex_rs = 7; mem_dest = 7; mem_regwrite = 1; branch_taken = 1;
    rst_n = 0;
    #1;
    chk("rst mid hilo_busy", hilo_busy, 0);
    chk("rst mid pc_write", pc_write, 0);
    chk("rst mid idex_bubble", idex_bubble, 1);
    chk("rst mid ifid_flush", ifid_flush, 0);
    chk("rst mid fwd_a", fwd_a, 0);
    chk("rst mid stall_cycles", stall_cycles, 0);
    @(negedge clk);
    clearIn();
    rst_n = 1;
    id_rd_hilo = 1;
    #1;
    chk("rst release hilo_busy", hilo_busy, 0);
    chk("rst release pc_write", pc_write, 1);
    @(negedge clk);
    #1;
    chk("rst release stall_cycles", stall_cycles, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
